// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scan and decode path.
// Key codes, encoded row values and the scan controller state encoding.
package keypad_pkg;

  localparam logic [3:0] KEY_ZERO     = 4'h0;
  localparam logic [3:0] KEY_ONE      = 4'h1;
  localparam logic [3:0] KEY_TWO      = 4'h2;
  localparam logic [3:0] KEY_THREE    = 4'h3;
  localparam logic [3:0] KEY_FOUR     = 4'h4;
  localparam logic [3:0] KEY_FIVE     = 4'h5;
  localparam logic [3:0] KEY_SIX      = 4'h6;
  localparam logic [3:0] KEY_SEVEN    = 4'h7;
  localparam logic [3:0] KEY_EIGHT    = 4'h8;
  localparam logic [3:0] KEY_NINE     = 4'h9;
  localparam logic [3:0] KEY_A        = 4'hA;
  localparam logic [3:0] KEY_B        = 4'hB;
  localparam logic [3:0] KEY_C        = 4'hC;
  localparam logic [3:0] KEY_D        = 4'hD;
  localparam logic [3:0] KEY_NUMERAL  = 4'hE;
  localparam logic [3:0] KEY_ASTERISK = 4'hF;

  localparam logic [1:0] ROW1 = 2'b11;
  localparam logic [1:0] ROW2 = 2'b10;
  localparam logic [1:0] ROW3 = 2'b01;
  localparam logic [1:0] ROW4 = 2'b00;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    PRESS   = 2'd1,
    REPORT  = 2'd2,
    RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/keypad_key_map.sv
// Combinational keypad position decode: column index and encoded row to key code.
// Shared with the existing decode path, so it carries no state.
module keypad_key_map
  import keypad_pkg::*;
(
  input  logic [1:0] col_idx,
  input  logic [1:0] row_code,
  output logic [3:0] key,
  output logic       keytype
);

  always_comb begin
    key = KEY_ZERO;
    case (col_idx)
      2'd0: begin
        case (row_code)
          ROW1:    key = KEY_A;
          ROW2:    key = KEY_B;
          ROW3:    key = KEY_C;
          default: key = KEY_D;
        endcase
      end
      2'd1: begin
        case (row_code)
          ROW1:    key = KEY_THREE;
          ROW2:    key = KEY_SIX;
          ROW3:    key = KEY_NINE;
          default: key = KEY_NUMERAL;
        endcase
      end
      2'd2: begin
        case (row_code)
          ROW1:    key = KEY_TWO;
          ROW2:    key = KEY_FIVE;
          ROW3:    key = KEY_EIGHT;
          default: key = KEY_ZERO;
        endcase
      end
      default: begin
        case (row_code)
          ROW1:    key = KEY_ONE;
          ROW2:    key = KEY_FOUR;
          ROW3:    key = KEY_SEVEN;
          default: key = KEY_ASTERISK;
        endcase
      end
    endcase
    keytype = (key <= KEY_NINE);
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad column scanner: rotates the column drive, debounces press and release,
// and hands exactly one key event per press to the consumer over valid/ready.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       row_valid,
  input  logic [1:0] row_code,
  input  logic       key_ready,
  output logic [1:0] col_sel,
  output logic [3:0] key,
  output logic       keytype,
  output logic       key_valid,
  output logic       busy
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] deb_q, deb_d;
  logic [1:0]       cand_col_q, cand_col_d;
  logic [1:0]       cand_row_q, cand_row_d;
  logic [3:0]       key_q, key_d;
  logic             keytype_q, keytype_d;
  logic             key_valid_q, key_valid_d;
  logic             rv_meta_q, rv_s_q;
  logic [1:0]       rc_meta_q, rc_s_q;

  logic [3:0]       map_key;
  logic             map_keytype;
  logic             dwell_last, deb_last, press_ok, accept;

  keypad_key_map u_key_map (
    .col_idx  (cand_col_q),
    .row_code (cand_row_q),
    .key      (map_key),
    .keytype  (map_keytype)
  );

  assign dwell_last = (dwell_q == DWELL_LAST);
  assign deb_last   = (deb_q == DEB_LAST);
  assign press_ok   = rv_s_q && (rc_s_q == cand_row_q);
  assign accept     = key_valid_q && key_ready;

  // Row inputs are asynchronous to clock; only the second-stage copies are used.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      dwell_q     <= '0;
      deb_q       <= '0;
      cand_col_q  <= 2'd0;
      cand_row_q  <= 2'd0;
      key_q       <= 4'd0;
      keytype_q   <= 1'b0;
      key_valid_q <= 1'b0;
      rv_meta_q   <= 1'b0;
      rv_s_q      <= 1'b0;
      rc_meta_q   <= 2'd0;
      rc_s_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      cand_col_q  <= cand_col_d;
      cand_row_q  <= cand_row_d;
      key_q       <= key_d;
      keytype_q   <= keytype_d;
      key_valid_q <= key_valid_d;
      rv_meta_q   <= row_valid;
      rv_s_q      <= rv_meta_q;
      rc_meta_q   <= row_code;
      rc_s_q      <= rc_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:    if (enable && dwell_last && rv_s_q) state_d = PRESS;
      PRESS: begin
        if (!enable || !press_ok) state_d = SCAN;
        else if (deb_last)        state_d = REPORT;
      end
      REPORT:  if (accept) state_d = RELEASE;
      RELEASE: if (!rv_s_q && deb_last) state_d = SCAN;
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    col_idx_d   = col_idx_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    cand_col_d  = cand_col_q;
    cand_row_d  = cand_row_q;
    key_d       = key_q;
    keytype_d   = keytype_q;
    key_valid_d = key_valid_q;
    case (state_q)
      SCAN: begin
        if (enable) begin
          if (dwell_last) begin
            dwell_d = '0;
            if (rv_s_q) begin
              cand_col_d = col_idx_q;
              cand_row_d = rc_s_q;
              deb_d      = '0;
            end else begin
              col_idx_d = col_idx_q + 2'd1;
            end
          end else begin
            dwell_d = dwell_q + CNT_ONE;
          end
        end
      end
      PRESS: begin
        if (!enable || !press_ok) begin
          col_idx_d = col_idx_q + 2'd1;
          dwell_d   = '0;
        end else begin
          deb_d = deb_q + CNT_ONE;
          if (deb_last) begin
            key_d       = map_key;
            keytype_d   = map_keytype;
            key_valid_d = 1'b1;
          end
        end
      end
      REPORT: begin
        if (accept) begin
          key_valid_d = 1'b0;
          deb_d       = '0;
        end
      end
      RELEASE: begin
        if (rv_s_q) begin
          deb_d = '0;
        end else if (deb_last) begin
          col_idx_d = col_idx_q + 2'd1;
          dwell_d   = '0;
        end else begin
          deb_d = deb_q + CNT_ONE;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy    = (state_q != SCAN);
    col_sel = ~col_idx_q;
  end

  assign key       = key_q;
  assign keytype   = keytype_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
// Samples 1 time unit after each rising edge; expected values are hand-derived.
module tb_keypad_scan_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       row_valid = 1'b0;
  logic [1:0] row_code = 2'b00;
  logic       key_ready = 1'b0;
  logic [1:0] col_sel;
  logic [3:0] key;
  logic       keytype;
  logic       key_valid;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  keypad_scan_ctrl #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8),
    .CNT_W           (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .row_valid (row_valid),
    .row_code  (row_code),
    .key_ready (key_ready),
    .col_sel   (col_sel),
    .key       (key),
    .keytype   (keytype),
    .key_valid (key_valid),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_col(input logic [1:0] target);
    int n = 0;
    do begin
      step();
      n++;
    end while (col_sel !== target && n < 40);
    chk("wait_col", {30'd0, col_sel}, {30'd0, target});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    chk("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [1:0] c;

    // reset state
    step();
    chk("rst_col_sel", {30'd0, col_sel}, 32'h3);
    chk("rst_key_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_key", {28'd0, key}, 32'd0);
    chk("rst_keytype", {31'd0, keytype}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;

    // 1: idle rotation, 4 cycles per column
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) step();
      c = 2'((i / 4) % 4);
      chk("scan_col_sel", {30'd0, col_sel}, {30'd0, ~c});
      chk("scan_key_valid", {31'd0, key_valid}, 32'd0);
      chk("scan_busy", {31'd0, busy}, 32'd0);
    end

    // 2 + 4: key 5 at column 2, held off by key_ready=0
    wait_col(2'b01);
    row_valid = 1'b1;
    row_code  = 2'b10;
    for (int i = 1; i <= 11; i++) step();
    chk("p5_kv_before", {31'd0, key_valid}, 32'd0);
    chk("p5_busy", {31'd0, busy}, 32'd1);
    step();
    chk("p5_kv", {31'd0, key_valid}, 32'd1);
    chk("p5_key", {28'd0, key}, 32'h5);
    chk("p5_keytype", {31'd0, keytype}, 32'd1);
    chk("p5_col_frozen", {30'd0, col_sel}, 32'h1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_kv", {31'd0, key_valid}, 32'd1);
      chk("hold_key", {28'd0, key}, 32'h5);
      chk("hold_col", {30'd0, col_sel}, 32'h1);
    end
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    chk("acc_kv", {31'd0, key_valid}, 32'd0);
    chk("acc_busy", {31'd0, busy}, 32'd1);

    // held key keeps the block in RELEASE, no repeat event
    for (int i = 0; i < 12; i++) begin
      step();
      chk("held_busy", {31'd0, busy}, 32'd1);
      chk("held_kv", {31'd0, key_valid}, 32'd0);
    end

    // 5: release with a one-sample bounce
    row_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    row_valid = 1'b1;
    step();
    row_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("rel_busy", {31'd0, busy}, 32'd1);
      chk("rel_kv", {31'd0, key_valid}, 32'd0);
    end
    step();
    chk("rel_done_busy", {31'd0, busy}, 32'd0);
    chk("rel_col_adv", {30'd0, col_sel}, 32'h0);
    chk("rel_done_kv", {31'd0, key_valid}, 32'd0);

    // 2b: asterisk at column 3
    row_valid = 1'b1;
    row_code  = 2'b00;
    for (int i = 1; i <= 11; i++) step();
    chk("pf_kv_before", {31'd0, key_valid}, 32'd0);
    step();
    chk("pf_kv", {31'd0, key_valid}, 32'd1);
    chk("pf_key", {28'd0, key}, 32'hF);
    chk("pf_keytype", {31'd0, keytype}, 32'd0);
    chk("pf_col", {30'd0, col_sel}, 32'h0);
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    row_valid = 1'b0;
    chk("pf_acc_kv", {31'd0, key_valid}, 32'd0);
    wait_idle();
    chk("pf_after_col", {30'd0, col_sel}, 32'h3);

    // 3: short press aborts without an event
    wait_col(2'b10);
    row_valid = 1'b1;
    row_code  = 2'b11;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("short_kv", {31'd0, key_valid}, 32'd0);
    end
    row_valid = 1'b0;
    step();
    step();
    chk("short_busy", {31'd0, busy}, 32'd1);
    step();
    chk("short_idle", {31'd0, busy}, 32'd0);
    chk("short_col", {30'd0, col_sel}, 32'h1);
    chk("short_kv_end", {31'd0, key_valid}, 32'd0);
    chk("short_key_kept", {28'd0, key}, 32'hF);

    // 6: asynchronous reset while an event is pending
    row_valid = 1'b1;
    row_code  = 2'b10;
    for (int i = 1; i <= 12; i++) step();
    chk("r6_kv", {31'd0, key_valid}, 32'd1);
    chk("r6_key", {28'd0, key}, 32'h5);
    #2;
    reset = 1'b0;
    #1;
    chk("r6_rst_kv", {31'd0, key_valid}, 32'd0);
    chk("r6_rst_key", {28'd0, key}, 32'd0);
    chk("r6_rst_col", {30'd0, col_sel}, 32'h3);
    chk("r6_rst_busy", {31'd0, busy}, 32'd0);
    chk("r6_rst_keytype", {31'd0, keytype}, 32'd0);
    row_valid = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("r6_scan_col0", {30'd0, col_sel}, 32'h3);
    step();
    chk("r6_scan_col1", {30'd0, col_sel}, 32'h2);
    chk("r6_scan_busy", {31'd0, busy}, 32'd0);
    chk("r6_scan_kv", {31'd0, key_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
